// File: rtl/eth_frame_rx_if.sv
// Signal bundle for eth_frame_rx: raw frame stream in, parsed header plus payload stream out.
// The master modport is the receiver itself; the slave modport is whatever surrounds it.
interface eth_frame_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic                  s_axis_tuser;

    logic                  m_eth_hdr_valid;
    logic                  m_eth_hdr_ready;
    logic [47:0]           m_eth_dest_mac;
    logic [47:0]           m_eth_src_mac;
    logic [15:0]           m_eth_type;

    logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep;
    logic                  m_eth_payload_axis_tvalid;
    logic                  m_eth_payload_axis_tready;
    logic                  m_eth_payload_axis_tlast;
    logic                  m_eth_payload_axis_tuser;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        input  m_eth_hdr_ready,
        output m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep, m_eth_payload_axis_tvalid,
        output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        input  m_eth_payload_axis_tready
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        output m_eth_hdr_ready,
        input  m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep, m_eth_payload_axis_tvalid,
        input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        output m_eth_payload_axis_tready
    );
endinterface

// File: rtl/eth_frame_rx.sv
// Ethernet frame receiver: splits the 14-byte MAC header off a byte stream and forwards the payload.
// Optional statistics counters are enabled with macro ETH_FRAME_RX_STATS_EN.
module eth_frame_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    eth_frame_rx_if.master bus,
    output logic        busy,
    output logic        error_header_early_termination
`ifdef ETH_FRAME_RX_STATS_EN
    ,
    output logic [31:0] stat_frame_count,
    output logic [31:0] stat_error_count
`endif
);
    typedef enum logic {HDR, PAYLOAD} state_t;

    state_t                state_reg;
    logic [3:0]            hdr_cnt_reg;
    logic                  hdr_valid_reg;
    logic [DATA_WIDTH-1:0] pay_data_reg;
    logic                  pay_valid_reg;
    logic                  pay_last_reg;
    logic                  pay_user_reg;
    logic                  error_reg;
    logic [111:0]          hdr_flat;

    logic in_ready;
    logic in_fire;
    logic hdr_fire;
    logic pay_fire;

    // Input readiness depends only on registered state and the downstream readies.
    always_comb begin
        if (state_reg == HDR) begin
            in_ready = !hdr_valid_reg;
        end else begin
            in_ready = bus.m_eth_payload_axis_tready || !pay_valid_reg;
        end
    end

    assign in_fire  = bus.s_axis_tvalid && in_ready;
    assign hdr_fire = in_fire && (state_reg == HDR);
    assign pay_fire = in_fire && (state_reg == PAYLOAD);

    genvar gi;
    generate
        for (gi = 0; gi < 14; gi++) begin : g_hdr_byte
            logic [7:0] byte_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byte_reg <= '0;
                end else if (hdr_fire && hdr_cnt_reg == 4'(gi)) begin
                    byte_reg <= bus.s_axis_tdata[7:0];
                end
            end
            // Byte 0 lands in the most significant byte of the destination MAC.
            assign hdr_flat[111 - 8*gi -: 8] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= HDR;
            hdr_cnt_reg   <= '0;
            hdr_valid_reg <= 1'b0;
            pay_data_reg  <= '0;
            pay_valid_reg <= 1'b0;
            pay_last_reg  <= 1'b0;
            pay_user_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            error_reg <= 1'b0;
            if (hdr_valid_reg && bus.m_eth_hdr_ready) begin
                hdr_valid_reg <= 1'b0;
            end
            if (pay_valid_reg && bus.m_eth_payload_axis_tready) begin
                pay_valid_reg <= 1'b0;
            end
            case (state_reg)
                HDR: begin
                    if (hdr_fire) begin
                        if (bus.s_axis_tlast) begin
                            hdr_cnt_reg <= '0;
                            error_reg   <= 1'b1;
                        end else if (hdr_cnt_reg == 4'd13) begin
                            hdr_cnt_reg   <= '0;
                            hdr_valid_reg <= 1'b1;
                            state_reg     <= PAYLOAD;
                        end else begin
                            hdr_cnt_reg <= hdr_cnt_reg + 4'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (pay_fire) begin
                        pay_data_reg  <= bus.s_axis_tdata;
                        pay_last_reg  <= bus.s_axis_tlast;
                        pay_user_reg  <= bus.s_axis_tlast && bus.s_axis_tuser;
                        pay_valid_reg <= 1'b1;
                        if (bus.s_axis_tlast) begin
                            state_reg <= HDR;
                        end
                    end
                end
                default: state_reg <= HDR;
            endcase
        end
    end

`ifdef ETH_FRAME_RX_STATS_EN
    logic [31:0] frame_count_reg;
    logic [31:0] error_count_reg;

    // Early termination and a bad payload tlast can never coincide: they occur in different states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_reg <= '0;
            error_count_reg <= '0;
        end else begin
            if (pay_fire && bus.s_axis_tlast) begin
                frame_count_reg <= frame_count_reg + 32'd1;
            end
            if ((hdr_fire && bus.s_axis_tlast) ||
                (pay_fire && bus.s_axis_tlast && bus.s_axis_tuser)) begin
                error_count_reg <= error_count_reg + 32'd1;
            end
        end
    end

    assign stat_frame_count = frame_count_reg;
    assign stat_error_count = error_count_reg;
`endif

    assign bus.s_axis_tready             = in_ready;
    assign bus.m_eth_hdr_valid           = hdr_valid_reg;
    assign bus.m_eth_dest_mac            = hdr_flat[111:64];
    assign bus.m_eth_src_mac             = hdr_flat[63:16];
    assign bus.m_eth_type                = hdr_flat[15:0];
    assign bus.m_eth_payload_axis_tdata  = pay_data_reg;
    assign bus.m_eth_payload_axis_tkeep  = {KEEP_WIDTH{1'b1}};
    assign bus.m_eth_payload_axis_tvalid = pay_valid_reg;
    assign bus.m_eth_payload_axis_tlast  = pay_last_reg;
    assign bus.m_eth_payload_axis_tuser  = pay_user_reg;

    assign busy                           = (state_reg == PAYLOAD) || (hdr_cnt_reg != 4'd0);
    assign error_header_early_termination = error_reg;
endmodule

// File: tb/tb_eth_frame_rx.sv
// Bench for eth_frame_rx: table vectors, hand-written corner sequences and random frames
// checked against a frame-level model (header = first 14 bytes, payload = the rest).
module tb_eth_frame_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_frame_rx_if bus ();
    logic busy;
    logic err_pulse;
`ifdef ETH_FRAME_RX_STATS_EN
    logic [31:0] stat_frame_count;
    logic [31:0] stat_error_count;
`endif

    eth_frame_rx dut (
        .clk                            (clk),
        .rst                            (rst),
        .bus                            (bus),
        .busy                           (busy),
        .error_header_early_termination (err_pulse)
`ifdef ETH_FRAME_RX_STATS_EN
        ,
        .stat_frame_count               (stat_frame_count),
        .stat_error_count               (stat_error_count)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        int          len;
        logic [15:0] et;
        bit          tu;
        bit          arp;
        int          exp_hdr;
        int          exp_plen;
        int          exp_err;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pmode = 0;
    int hmode = 0;
    bit abort = 1'b0;
    int acc14_cyc = 0;
    int first_acc_cyc = 0;
    int last_acc_cyc = 0;
    int first_pay_cyc = 0;

    logic [7:0]   frm[$];
    logic [111:0] exp_hdr_q[$];
    logic [111:0] obs_hdr_q[$];
    beat_t        exp_pay_q[$];
    beat_t        obs_pay_q[$];
    int           exp_err = 0;
    int           obs_err = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Downstream ready generators: 0 always, 1 toggle, 2 random, 3 held low.
    initial begin
        bus.m_eth_payload_axis_tready = 1'b1;
        bus.m_eth_hdr_ready           = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (pmode)
                0: bus.m_eth_payload_axis_tready = 1'b1;
                1: bus.m_eth_payload_axis_tready = !bus.m_eth_payload_axis_tready;
                2: bus.m_eth_payload_axis_tready = 1'($urandom_range(0, 1));
                default: bus.m_eth_payload_axis_tready = 1'b0;
            endcase
            case (hmode)
                0: bus.m_eth_hdr_ready = 1'b1;
                1: bus.m_eth_hdr_ready = !bus.m_eth_hdr_ready;
                2: bus.m_eth_hdr_ready = 1'($urandom_range(0, 1));
                default: bus.m_eth_hdr_ready = 1'b0;
            endcase
        end
    end

    // Output monitor, sampled mid-cycle: records transfers and checks stalled beats hold.
    initial begin
        bit    stall_prev;
        beat_t prev_beat;
        beat_t cur;
        stall_prev = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            cur = {bus.m_eth_payload_axis_tdata, bus.m_eth_payload_axis_tlast,
                   bus.m_eth_payload_axis_tuser};
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_hold", {bus.m_eth_payload_axis_tvalid, cur}, {1'b1, prev_beat});
                end
                if (bus.m_eth_hdr_valid && bus.m_eth_hdr_ready) begin
                    obs_hdr_q.push_back({bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type});
                end
                if (bus.m_eth_payload_axis_tvalid && bus.m_eth_payload_axis_tready) begin
                    if (obs_pay_q.size() == 0) first_pay_cyc = cyc;
                    obs_pay_q.push_back(cur);
                end
                if (err_pulse) obs_err++;
                stall_prev = bus.m_eth_payload_axis_tvalid && !bus.m_eth_payload_axis_tready;
                prev_beat  = cur;
            end
        end
    end

    function automatic void build_frame(int len, bit arp, logic [15:0] et);
        logic [63:0] arp_pl;
        arp_pl = 64'h0001_0800_0604_0001;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (arp && i < 6) b = 8'hff;
            else if (arp && i == 6) b = 8'h5a;
            else if (arp && i < 12) b = 8'(8'h50 + i - 6);
            else if (i == 12) b = et[15:8];
            else if (i == 13) b = et[7:0];
            else if (arp && i < 22) b = arp_pl[63 - 8*(i-14) -: 8];
            frm.push_back(b);
        end
    endfunction

    // Reference: a frame shorter than 15 bytes is one error; otherwise one header and len-14 beats.
    function automatic void model_frame(bit tu);
        logic [111:0] h;
        int n;
        n = frm.size();
        if (n < 15) begin
            exp_err++;
        end else begin
            h = '0;
            for (int i = 0; i < 14; i++) h[111 - 8*i -: 8] = frm[i];
            exp_hdr_q.push_back(h);
            for (int i = 14; i < n; i++) begin
                exp_pay_q.push_back({frm[i], (i == n-1), (i == n-1) && tu});
            end
        end
    endfunction

    task automatic send_frame(input bit tu, input bit bubbles);
        int n;
        int w;
        n = frm.size();
        model_frame(tu);
        for (int i = 0; i < n; i++) begin
            if (abort) break;
            if (bubbles && $urandom_range(0, 3) == 0) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.s_axis_tdata  = frm[i];
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (i == n-1);
            bus.s_axis_tuser  = (i == n-1) ? tu : 1'($urandom_range(0, 1));
            w = 0;
            forever begin
                @(negedge clk);
                if (bus.s_axis_tready) begin
                    if (i == 0) first_acc_cyc = cyc;
                    if (i == 14) acc14_cyc = cyc;
                    last_acc_cyc = cyc;
                    @(posedge clk);
                    #1;
                    break;
                end
                @(posedge clk);
                #1;
                if (abort) break;
                w++;
                if (w > 500) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL send_timeout: byte %0d never accepted, required accepted", i);
                    bus.s_axis_tvalid = 1'b0;
                    return;
                end
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || bus.m_eth_payload_axis_tvalid || bus.m_eth_hdr_valid || err_pulse)
                   && t < 1000);
        if (t >= 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: outputs still active after %0d cycles, required idle", t);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic void clear_all();
        exp_hdr_q.delete();
        obs_hdr_q.delete();
        exp_pay_q.delete();
        obs_pay_q.delete();
        exp_err = 0;
        obs_err = 0;
    endfunction

    function automatic void check_all(string tag);
        int m;
        chk({tag, "_nhdr"}, obs_hdr_q.size(), exp_hdr_q.size());
        m = (obs_hdr_q.size() < exp_hdr_q.size()) ? obs_hdr_q.size() : exp_hdr_q.size();
        for (int i = 0; i < m; i++) chk({tag, "_hdr"}, obs_hdr_q[i], exp_hdr_q[i]);
        chk({tag, "_nbeat"}, obs_pay_q.size(), exp_pay_q.size());
        m = (obs_pay_q.size() < exp_pay_q.size()) ? obs_pay_q.size() : exp_pay_q.size();
        for (int i = 0; i < m; i++) chk({tag, "_beat"}, obs_pay_q[i], exp_pay_q[i]);
        chk({tag, "_err"}, obs_err, exp_err);
        clear_all();
    endfunction

    initial begin
        vec_t         tbl[6];
        logic [111:0] h0;
        int           f1;
        int           t;
`ifdef ETH_FRAME_RX_STATS_EN
        logic [31:0]  fc0;
        logic [31:0]  ec0;
`endif
        tbl[0] = '{42, 16'h0806, 1'b0, 1'b1, 1, 28, 0};
        tbl[1] = '{10, 16'h0800, 1'b0, 1'b0, 0, 0, 1};
        tbl[2] = '{14, 16'h0800, 1'b1, 1'b0, 0, 0, 1};
        tbl[3] = '{15, 16'h0800, 1'b0, 1'b0, 1, 1, 0};
        tbl[4] = '{60, 16'h86dd, 1'b1, 1'b0, 1, 46, 0};
        tbl[5] = '{1, 16'h0000, 1'b0, 1'b0, 0, 0, 1};

        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;

        #2;
        chk("rst_hdr_valid", bus.m_eth_hdr_valid, 1'b0);
        chk("rst_pay_valid", bus.m_eth_payload_axis_tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_pulse, 1'b0);
        chk("rst_tkeep", bus.m_eth_payload_axis_tkeep, 1'b1);
        chk("rst_dest", bus.m_eth_dest_mac, 48'h0);
        chk("rst_in_ready", bus.s_axis_tready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            pmode = (v == 0) ? 0 : 2;
            hmode = (v == 0) ? 0 : 2;
            repeat (2) @(posedge clk);
            #1;
            build_frame(tbl[v].len, tbl[v].arp, tbl[v].et);
            send_frame(tbl[v].tu, 1'b0);
            drain();
            chk("tbl_nhdr", obs_hdr_q.size(), tbl[v].exp_hdr);
            chk("tbl_plen", obs_pay_q.size(), tbl[v].exp_plen);
            chk("tbl_err", obs_err, tbl[v].exp_err);
            if (v == 0) begin
                if (obs_hdr_q.size() > 0) begin
                    h0 = obs_hdr_q[0];
                    chk("arp_type", h0[15:0], 16'h0806);
                    chk("arp_src", h0[63:16], 48'h5a5152535455);
                end
                chk("pay_latency", first_pay_cyc - acc14_cyc, 1);
            end
            check_all("tbl");
        end

        // Payload backpressure with a toggling ready.
        pmode = 1;
        hmode = 0;
        build_frame(42, 1'b1, 16'h0806);
        send_frame(1'b0, 1'b0);
        drain();
        check_all("bp");

        // Truncated frame followed immediately by a good one.
        pmode = 0;
        repeat (2) @(posedge clk);
        #1;
`ifdef ETH_FRAME_RX_STATS_EN
        fc0 = stat_frame_count;
        ec0 = stat_error_count;
`endif
        build_frame(10, 1'b0, 16'h0800);
        send_frame(1'b0, 1'b0);
        build_frame(42, 1'b1, 16'h0806);
        send_frame(1'b0, 1'b0);
        drain();
`ifdef ETH_FRAME_RX_STATS_EN
        chk("stat_frames", stat_frame_count - fc0, 32'd1);
        chk("stat_errors", stat_error_count - ec0, 32'd1);
`endif
        check_all("early");

        // Header held: payload completes, then the next frame waits for the header handshake.
        hmode = 3;
        repeat (2) @(posedge clk);
        #1;
        build_frame(42, 1'b1, 16'h0806);
        send_frame(1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("held_beats", obs_pay_q.size(), 28);
        chk("held_hdr_valid", bus.m_eth_hdr_valid, 1'b1);
        build_frame(30, 1'b0, 16'h0800);
        bus.s_axis_tdata  = frm[0];
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("held_in_ready", bus.s_axis_tready, 1'b0);
        end
        hmode = 0;
        send_frame(1'b0, 1'b0);
        drain();
        check_all("held");

        // Back-to-back frames at full rate.
        pmode = 0;
        hmode = 0;
        repeat (2) @(posedge clk);
        #1;
        build_frame(42, 1'b1, 16'h0806);
        send_frame(1'b0, 1'b0);
        f1 = first_acc_cyc;
        build_frame(42, 1'b0, 16'h0800);
        send_frame(1'b1, 1'b0);
        chk("throughput", last_acc_cyc - f1, 83);
        drain();
        check_all("b2b");

        // Reset mid-payload.
        build_frame(42, 1'b1, 16'h0806);
        abort = 1'b0;
        fork
            send_frame(1'b0, 1'b0);
            begin
                t = 0;
                while (obs_pay_q.size() < 5 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                abort = 1'b1;
                @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                chk("mid_rst_hdr_valid", bus.m_eth_hdr_valid, 1'b0);
                chk("mid_rst_pay_valid", bus.m_eth_payload_axis_tvalid, 1'b0);
                chk("mid_rst_busy", busy, 1'b0);
                repeat (2) @(posedge clk);
                #3;
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_all();
        build_frame(42, 1'b1, 16'h0806);
        send_frame(1'b0, 1'b0);
        drain();
        check_all("post_rst");

        // Random frames, random bubbles and random downstream readiness.
        for (int k = 0; k < 40; k++) begin
            pmode = $urandom_range(0, 2);
            hmode = $urandom_range(0, 2);
            build_frame($urandom_range(1, 48), 1'b0, 16'($urandom));
            send_frame(1'($urandom_range(0, 1)), 1'b1);
            if (k % 5 == 4) begin
                drain();
                check_all("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
